s400_lamp_monitor: RTL



---
 rtl/s400_lamp_monitor_if.sv | 27 ++
 rtl/s400_lamp_monitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/s400_lamp_monitor_if.sv
// Lamp-monitor signal bundle: the six lamp drives plus FM/ACK towards the
// monitor, and the latched fault status back to the supervisory logic.
interface s400_lamp_monitor_if;
    logic       GRN1;
    logic       YLW1;
    logic       RED1;
    logic       GRN2;
    logic       YLW2;
    logic       RED2;
    logic       FM;
    logic       ACK;
    logic       FAULT;
    logic [2:0] FCODE;
    logic       FHEAD;
    logic       FLASH_REQ;
    logic [7:0] FCNT;

    modport master (
        output GRN1, YLW1, RED1, GRN2, YLW2, RED2, FM, ACK,
        input  FAULT, FCODE, FHEAD, FLASH_REQ, FCNT
    );

    modport slave (
        input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, FM, ACK,
        output FAULT, FCODE, FHEAD, FLASH_REQ, FCNT
    );
endinterface

// File: rtl/s400_lamp_monitor.sv
// Two-stage conflict/malfunction monitor for a two-head signal: samples the
// lamps, checks the signal discipline and latches the first fault with a code.
module s400_lamp_monitor #(
    parameter int YMIN     = 3,
    parameter int DARK_MAX = 4,
    parameter int CW       = 4
) (
    input  logic               CK,
    input  logic               CLR,
    s400_lamp_monitor_if.slave mon
);
    typedef enum logic [2:0] {ST_R, ST_G, ST_Y, ST_DARK, ST_MULTI} head_st_e;
    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_MULTI    = 3'd2,
        FC_DARK     = 3'd3,
        FC_SEQ      = 3'd4,
        FC_SHORT_Y  = 3'd5
    } fcode_e;

    localparam logic [CW-1:0] YMIN_C   = CW'(YMIN);
    localparam logic [CW-1:0] DARK_C   = CW'(DARK_MAX);
    localparam logic [CW-1:0] CNT_SAT  = '1;
    localparam logic [2:0]    LAMP_RED = 3'b001;  // lamp vectors are {G, Y, R}

    logic [2:0]    lamp_in [2];
    logic [2:0]    lamp_q  [2];
    logic          fm_q, fm_prev_q, fm_chg, seq_en;

    head_st_e      st      [2];
    head_st_e      trk_q   [2];
    head_st_e      trk_d   [2];
    logic [CW-1:0] ycnt_q  [2];
    logic [CW-1:0] ycnt_d  [2];
    logic [CW-1:0] dcnt_q  [2];
    logic [CW-1:0] dcnt_d  [2];
    logic [1:0]    multi_f, dark_f, seq_f, sy_f;

    logic          conflict, det, det_head;
    fcode_e        det_code;
    logic          fault_q, fault_d, fhead_q, fhead_d, flash_q;
    fcode_e        fcode_q, fcode_d;
    logic [7:0]    fcnt_q, fcnt_d;

    assign lamp_in[0] = {mon.GRN1, mon.YLW1, mon.RED1};
    assign lamp_in[1] = {mon.GRN2, mon.YLW2, mon.RED2};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge CK) begin
        if (CLR) begin
            lamp_q[0] <= LAMP_RED;
            lamp_q[1] <= LAMP_RED;
            fm_q      <= 1'b0;
            fm_prev_q <= 1'b0;
        end else begin
            lamp_q[0] <= lamp_in[0];
            lamp_q[1] <= lamp_in[1];
            fm_q      <= mon.FM;
            fm_prev_q <= fm_q;
        end
    end

    assign fm_chg = fm_q ^ fm_prev_q;
    assign seq_en = !fm_q && !fm_chg;

    // Flash forbids any green; normal mode forbids both heads showing go.
    assign conflict = fm_q ? (lamp_q[0][2] | lamp_q[1][2])
                           : ((lamp_q[0][2] | lamp_q[0][1]) & (lamp_q[1][2] | lamp_q[1][1]));

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        for (int h = 0; h < 2; h++) begin
            st[h]      = ST_MULTI;
            trk_d[h]   = trk_q[h];
            ycnt_d[h]  = ycnt_q[h];
            dcnt_d[h]  = '0;
            multi_f[h] = 1'b0;
            dark_f[h]  = 1'b0;
            seq_f[h]   = 1'b0;
            sy_f[h]    = 1'b0;

            case (lamp_q[h])
                3'b100:  st[h] = ST_G;
                3'b010:  st[h] = ST_Y;
                3'b001:  st[h] = ST_R;
                3'b000:  st[h] = ST_DARK;
                default: st[h] = ST_MULTI;
            endcase

            multi_f[h] = (st[h] == ST_MULTI);

            if (st[h] == ST_DARK) begin
                dcnt_d[h] = (dcnt_q[h] == CNT_SAT) ? dcnt_q[h] : dcnt_q[h] + 1'b1;
            end
            dark_f[h] = (st[h] == ST_DARK) && (dcnt_d[h] >= DARK_C);

            // Dark and multi samples are compared against the last real colour.
            seq_f[h] = seq_en && (st[h] inside {ST_R, ST_G, ST_Y}) && (st[h] != trk_q[h])
                       && !((trk_q[h] == ST_R && st[h] == ST_G)
                         || (trk_q[h] == ST_G && st[h] == ST_Y)
                         || (trk_q[h] == ST_Y && st[h] == ST_R));
            sy_f[h]  = seq_en && (trk_q[h] == ST_Y) && (st[h] == ST_R) && (ycnt_q[h] < YMIN_C);

            if (st[h] inside {ST_R, ST_G, ST_Y}) begin
                trk_d[h] = st[h];
            end

            if (fm_chg) begin
                ycnt_d[h] = '0;
            end else if (st[h] == ST_Y) begin
                if (trk_q[h] != ST_Y) begin
                    ycnt_d[h] = CW'(1);
                end else if (ycnt_q[h] != CNT_SAT) begin
                    ycnt_d[h] = ycnt_q[h] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        det      = 1'b1;
        det_code = FC_NONE;
        det_head = 1'b0;
        if (conflict) begin
            det_code = FC_CONFLICT;
        end else if (multi_f[0]) begin
            det_code = FC_MULTI;
        end else if (multi_f[1]) begin
            det_code = FC_MULTI;
            det_head = 1'b1;
        end else if (seq_f[0]) begin
            det_code = FC_SEQ;
        end else if (seq_f[1]) begin
            det_code = FC_SEQ;
            det_head = 1'b1;
        end else if (sy_f[0]) begin
            det_code = FC_SHORT_Y;
        end else if (sy_f[1]) begin
            det_code = FC_SHORT_Y;
            det_head = 1'b1;
        end else if (dark_f[0]) begin
            det_code = FC_DARK;
        end else if (dark_f[1]) begin
            det_code = FC_DARK;
            det_head = 1'b1;
        end else begin
            det = 1'b0;
        end
    end

    always_comb begin
        fault_d = fault_q;
        fcode_d = fcode_q;
        fhead_d = fhead_q;
        fcnt_d  = fcnt_q;
        if (det && (!fault_q || mon.ACK)) begin
            fault_d = 1'b1;
            fcode_d = det_code;
            fhead_d = det_head;
            fcnt_d  = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
        end else if (fault_q && mon.ACK) begin
            fault_d = 1'b0;
            fcode_d = FC_NONE;
            fhead_d = 1'b0;
        end
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            for (int h = 0; h < 2; h++) begin
                trk_q[h]  <= ST_R;
                ycnt_q[h] <= '0;
                dcnt_q[h] <= '0;
            end
            fault_q <= 1'b0;
            fcode_q <= FC_NONE;
            fhead_q <= 1'b0;
            fcnt_q  <= 8'd0;
            flash_q <= 1'b0;
        end else begin
            for (int h = 0; h < 2; h++) begin
                trk_q[h]  <= trk_d[h];
                ycnt_q[h] <= ycnt_d[h];
                dcnt_q[h] <= dcnt_d[h];
            end
            fault_q <= fault_d;
            fcode_q <= fcode_d;
            fhead_q <= fhead_d;
            fcnt_q  <= fcnt_d;
            flash_q <= fault_d;
        end
    end

    assign mon.FAULT     = fault_q;
    assign mon.FCODE     = fcode_q;
    assign mon.FHEAD     = fhead_q;
    assign mon.FLASH_REQ = flash_q;
    assign mon.FCNT      = fcnt_q;
endmodule
